// File: rtl/timer_compare.sv
// Compare/interrupt unit fed by the free-running timer count.
// One event per distinct count value; optional periodic compare advance.
module timer_compare #(
  parameter int CNT_W  = 32,
  parameter int MCNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_i,
  input  logic [1:0]       A,
  input  logic [31:0]      WD,
  input  logic             WE,
  output logic [31:0]      RD,
  output logic             irq
);

  logic [CNT_W-1:0]  cmp;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  count_prev;
  logic [2:0]        ctrl;
  logic              match;
  logic              overrun;
  logic [MCNT_W-1:0] mcount;

  logic en, periodic, ie;
  logic hit;
  logic wr_cmp, wr_per, wr_ctrl, wr_stat;
  logic clr_match, clr_ovr, clr_mcnt;
  logic [MCNT_W-1:0] mcount_inc;

  assign en       = ctrl[0];
  assign periodic = ctrl[1];
  assign ie       = ctrl[2];

  // a held count must not retrigger, so require a value change
  assign hit = en
             & (count_i == cmp)
             & (count_i != count_prev);

  assign wr_cmp  = WE & (A == 2'd0);
  assign wr_per  = WE & (A == 2'd1);
  assign wr_ctrl = WE & (A == 2'd2);
  assign wr_stat = WE & (A == 2'd3);

  assign clr_match = wr_stat & WD[0];
  assign clr_ovr   = wr_stat & WD[1];
  assign clr_mcnt  = wr_stat & WD[8];

  assign mcount_inc = (&mcount) ? mcount
                    : mcount + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp        <= '0;
      period     <= '0;
      count_prev <= '0;
      ctrl       <= '0;
      match      <= 1'b0;
      overrun    <= 1'b0;
      mcount     <= '0;
    end else begin
      count_prev <= count_i;

      if (wr_cmp)
        cmp <= WD[CNT_W-1:0];
      else if (hit && periodic)
        cmp <= cmp + period;

      if (wr_per)
        period <= WD[CNT_W-1:0];

      if (wr_ctrl)
        ctrl <= WD[2:0];

      if (hit)
        match <= 1'b1;
      else if (clr_match)
        match <= 1'b0;

      if (hit && match)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      if (hit)
        mcount <= clr_mcnt ? MCNT_W'(1)
                           : mcount_inc;
      else if (clr_mcnt)
        mcount <= '0;
    end
  end

  logic [31:0] stat_rd;

  assign stat_rd = (32'(mcount) << 8)
                 | {30'b0, overrun, match};

  always_comb begin
    RD = '0;
    unique case (A)
      2'd0: RD = 32'(cmp);
      2'd1: RD = 32'(period);
      2'd2: RD = {29'b0, ctrl};
      2'd3: RD = stat_rd;
    endcase
  end

  assign irq = match & ie;

endmodule

// File: tb/tb_timer_compare.sv
// Directed bench for timer_compare: vector table plus
// hand sequences for periodic, wrap and same-cycle cases.
module tb_timer_compare;

  localparam logic [1:0] R_CMP  = 2'd0;
  localparam logic [1:0] R_PER  = 2'd1;
  localparam logic [1:0] R_CTRL = 2'd2;
  localparam logic [1:0] R_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] count_i = '0;
  logic [1:0]  A = '0;
  logic [31:0] WD = '0;
  logic        WE = 1'b0;
  logic [31:0] RD;
  logic        irq;

  int n_run = 0;
  int n_fail = 0;

  timer_compare dut (
    .clk     (clk),
    .rst     (rst),
    .count_i (count_i),
    .A       (A),
    .WD      (WD),
    .WE      (WE),
    .RD      (RD),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [31:0] cnt;
    int          n;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic w,
                      input logic [1:0] wa,
                      input logic [31:0] wd,
                      input logic [31:0] cnt,
                      input logic [1:0] ra);
    @(negedge clk);
    rst = r;
    WE = w;
    A = wa;
    WD = wd;
    count_i = cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    WE = 1'b0;
    A = ra;
    #1;
  endtask

  task automatic rd_chk(input string nm,
                        input logic [1:0] ra,
                        input logic [31:0] exp);
    A = ra;
    #1;
    chk(nm, RD, exp);
  endtask

  task automatic irq_chk(input string nm,
                         input logic exp);
    chk(nm, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    vecs[0]  = '{1, 0, R_CMP,  0,     0, 1, R_STAT, 0,     0, "rst_stat"};
    vecs[1]  = '{1, 0, R_CMP,  0,     0, 1, R_CMP,  0,     0, "rst_cmp"};
    vecs[2]  = '{0, 1, R_CTRL, 1,     0, 1, R_CTRL, 1,     0, "en_only"};
    vecs[3]  = '{0, 0, R_CMP,  0,     0, 10, R_STAT, 0,    0, "zero_nohit"};
    vecs[4]  = '{0, 1, R_CMP,  5,     3, 1, R_CMP,  5,     0, "cmp5"};
    vecs[5]  = '{0, 1, R_CTRL, 5,     4, 1, R_CTRL, 5,     0, "ctrl_en_ie"};
    vecs[6]  = '{0, 0, R_CMP,  0,     5, 1, R_STAT, 32'h101, 1, "hit5"};
    vecs[7]  = '{0, 0, R_CMP,  0,     5, 19, R_STAT, 32'h101, 1, "hold5"};
    vecs[8]  = '{0, 1, R_STAT, 32'h103, 5, 1, R_STAT, 0,   0, "w1c_all"};
    vecs[9]  = '{0, 1, R_PER,  10,    0, 1, R_PER,  10,    0, "per10"};
    vecs[10] = '{0, 1, R_CMP,  10,    0, 1, R_CMP,  10,    0, "cmp10"};
    vecs[11] = '{0, 1, R_CTRL, 7,     0, 1, R_CTRL, 7,     0, "ctrl_per"};

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++)
        step(vecs[i].r, vecs[i].we, vecs[i].wa,
             vecs[i].wd, vecs[i].cnt, vecs[i].ra);
      chk({vecs[i].name, "_rd"}, RD, vecs[i].exp_rd);
      irq_chk({vecs[i].name, "_irq"}, vecs[i].exp_irq);
    end

    // periodic: hits at 10, 20, 30 with W1C after each irq
    begin
      logic clr;
      clr = 1'b0;
      for (int c = 1; c <= 35; c++) begin
        step(0, clr, R_STAT, 1, c, R_STAT);
        irq_chk($sformatf("per_irq_%0d", c),
                (c == 10) || (c == 20) || (c == 30));
        clr = irq;
      end
    end
    rd_chk("per_cmp40", R_CMP, 40);
    rd_chk("per_stat", R_STAT, 32'h300);

    // wrap of periodic advance, then overrun
    step(0, 1, R_STAT, 32'h103, 32'h100, R_STAT);
    chk("wr_clr", RD, 0);
    step(0, 1, R_PER, 32'h20, 32'h100, R_PER);
    chk("wr_per", RD, 32'h20);
    step(0, 1, R_CMP, 32'hFFFF_FFF0, 32'h100, R_CMP);
    chk("wr_cmp", RD, 32'hFFFF_FFF0);
    step(0, 0, R_CMP, 0, 32'hFFFF_FFEF, R_STAT);
    chk("wr_pre", RD, 0);
    step(0, 0, R_CMP, 0, 32'hFFFF_FFF0, R_CMP);
    chk("wr_cmp_wrap", RD, 32'h10);
    irq_chk("wr_irq1", 1);
    step(0, 0, R_CMP, 0, 0, R_STAT);
    chk("wr_stat1", RD, 32'h101);
    step(0, 0, R_CMP, 0, 32'h10, R_STAT);
    chk("wr_ovr", RD, 32'h203);
    irq_chk("wr_irq2", 1);

    // same-cycle hit with W1C, MCOUNT clear, CMP write
    step(0, 1, R_STAT, 32'h103, 32'h11, R_STAT);
    chk("sc_clr", RD, 0);
    step(0, 1, R_STAT, 1, 32'h30, R_STAT);
    chk("sc_w1c_hit", RD, 32'h101);
    step(0, 1, R_STAT, 32'h100, 32'h50, R_STAT);
    chk("sc_mclr_hit", RD, 32'h103);
    step(0, 1, R_CMP, 100, 32'h70, R_CMP);
    chk("sc_cmpwr", RD, 100);
    rd_chk("sc_cmpwr_stat", R_STAT, 32'h203);

    // EN=0 blocks hits
    step(0, 1, R_STAT, 32'h103, 32'h70, R_STAT);
    chk("en0_clr", RD, 0);
    step(0, 1, R_CTRL, 6, 32'h70, R_CTRL);
    chk("en0_ctrl", RD, 6);
    step(0, 0, R_CMP, 0, 100, R_STAT);
    chk("en0_nohit", RD, 0);
    irq_chk("en0_irq", 0);
    rd_chk("en0_cmp", R_CMP, 100);

    // IE toggled with MATCH set
    step(0, 1, R_CTRL, 3, 101, R_CTRL);
    chk("ie0_ctrl", RD, 3);
    step(0, 0, R_CMP, 0, 100, R_STAT);
    chk("ie0_match", RD, 32'h101);
    irq_chk("ie0_irq", 0);
    rd_chk("ie0_cmp", R_CMP, 132);
    step(0, 1, R_CTRL, 7, 100, R_CTRL);
    irq_chk("ie1_irq", 1);
    step(0, 1, R_CTRL, 3, 100, R_CTRL);
    irq_chk("ie_off_irq", 0);

    // reset beats a concurrent write and hit
    step(1, 1, R_CMP, 55, 132, R_CMP);
    chk("mrst_cmp", RD, 0);
    rd_chk("mrst_per", R_PER, 0);
    rd_chk("mrst_ctrl", R_CTRL, 0);
    rd_chk("mrst_stat", R_STAT, 0);
    irq_chk("mrst_irq", 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_compare.md
Name: timer_compare

Overview:
- Memory-mapped compare/interrupt unit that sits directly downstream of the free-running timer peripheral.
- Consumes the timer's 32-bit count value and raises a match flag and interrupt when the count reaches a programmed compare value.
- Supports one-shot and periodic (auto-advancing compare) modes.
- Accessed by the core through the same WD/WE/RD register-bus style as the timer.

Parameters:
- CNT_W, 32, width of the count input and of the CMP/PERIOD registers.
- MCNT_W, 8, width of the saturating match counter in STATUS.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- count_i  input  CNT_W  current timer value, driven by the timer's RD
- A  input  2  register select: 0=CMP, 1=PERIOD, 2=CTRL, 3=STATUS
- WD  input  32  write data
- WE  input  1  write enable; the write to register A takes effect on the rising edge
- RD  output  32  read data, combinational mux of the register selected by A
- irq  output  1  interrupt request, equal to STATUS.MATCH & CTRL.IE

Behaviour:
- Reset (rst=1 at a rising edge): CMP=0, PERIOD=0, CTRL=0, STATUS=0, count_prev=0. irq=0 and RD reflects the zeroed registers.
- CTRL bits:
  - [0] EN
  - [1] PERIODIC
  - [2] IE
  - others read 0
- STATUS bits:
  - [0] MATCH
  - [1] OVERRUN
  - [15:8] MCOUNT
  - others read 0
- count_prev register: loads count_i every cycle, regardless of EN.
- Match event: hit = EN & (count_i == CMP) & (count_i != count_prev).
  - The timer holds its value for many cycles, so one count value produces exactly one event.
  - Any value change counts, including a software write of the timer to exactly CMP.
- On a hit, at the same rising edge:
  - MATCH<=1.
  - OVERRUN<=1 if MATCH was already 1.
  - MCOUNT<=MCOUNT+1, saturating at 2^MCNT_W-1.
  - If PERIODIC=1: CMP<=CMP+PERIOD, modulo 2^CNT_W (wraps, no carry kept).
  - If PERIODIC=0: CMP unchanged.
- Latency: count_i becomes equal to CMP in cycle n; MATCH and irq are high from cycle n+1. Total delay from timer tick to irq is 1 cycle.
- CMP and PERIOD writes: take the full WD[CNT_W-1:0].
- CTRL write: takes WD[2:0].
- STATUS write:
  - WD[0]=1 clears MATCH (write-1-to-clear).
  - WD[1]=1 clears OVERRUN.
  - WD[8]=1 clears MCOUNT.
  - Zero bits leave the corresponding state unchanged.
- Simultaneous events:
  - Hit and CMP write in the same cycle: the hit is evaluated against the old CMP. The written value wins; the periodic advance is discarded.
  - Hit and W1C of MATCH in the same cycle: set wins, so MATCH stays 1.
  - Hit and MCOUNT clear in the same cycle: MCOUNT=1.
  - Hit and a CTRL write that clears EN: the hit is evaluated with the old EN, so the event still registers.
- EN=0: no hits occur. STATUS and CMP hold their values, and irq still follows MATCH&IE.
- IE=0: MATCH still sets, irq=0. Setting IE later asserts irq the cycle after the write if MATCH=1.
- PERIOD=0 with PERIODIC=1: CMP stays fixed, so a match occurs each time count_i returns to CMP (after timer wrap or a software write).
- Reset mid-operation: reset overrides any concurrent write or hit.

Test Plan:
- Reset, then drive count_i=0 for 10 cycles with EN=1, CMP=0 -> no hit (count_prev=0), irq=0, STATUS=0.
- CMP=5, CTRL=0b101, step count_i 3,4,5 and hold 5 for 20 cycles -> MATCH=1 and irq=1 starting the cycle after count_i=5; MCOUNT=1, not 20.
- PERIODIC: CMP=10, PERIOD=10, CTRL=0b111, step count_i 0..35 with W1C after each irq -> hits at 10, 20, 30; CMP reads 40; MCOUNT=3; OVERRUN=0.
- Wrap: CMP=0xFFFFFFF0, PERIOD=0x20, periodic, count_i reaches 0xFFFFFFF0 -> CMP reads 0x00000010. Without clearing, a second hit at 0x10 -> OVERRUN=1, MCOUNT=2.
- Same-cycle W1C of MATCH and hit -> MATCH remains 1. Same-cycle CMP write of 100 and hit -> CMP=100, MATCH=1.
- EN=0, count_i passes CMP -> no flag. Then IE toggled with MATCH pre-set -> irq follows IE one cycle after the write. rst asserted mid-run -> all registers 0 next cycle.
